soc_rst_seq: RTL and testbench

Parametrised reset sequencer for the SoC top level. It waits for a filtered PLL-lock indication, then releases `NUM_CH` independent active-high reset outputs in fixed order, with a programmable per-channel delay between releases. Typical channel order is SDRAM controller, Wishbone fabric, peripherals, CPU. It re-asserts all resets on lock loss, on a software reset request, or on an optional watchdog timeout.

---
 rtl/soc_rst_seq.sv | 169 ++++++++++++++++
 tb/tb_soc_rst_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/soc_rst_seq.sv
// rtl/soc_rst_seq.sv - SoC reset sequencer: filtered PLL lock, ordered per-channel release, optional watchdog
// Optional watchdog abort is built when SOC_RST_SEQ_WDT_EN is defined.
module soc_rst_seq #(
    parameter int                             NUM_CH      = 4,
    parameter int                             CNT_WIDTH   = 16,
    parameter logic [NUM_CH*CNT_WIDTH-1:0]    CH_DELAY    = {16'd100, 16'd50, 16'd10, 16'd0},
    parameter int                             SYNC_STAGES = 2,
    parameter int                             LOCK_FILTER = 8,
    parameter int                             WDT_WIDTH   = 20
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              pll_locked_i,
    input  logic              sw_rst_i,
    input  logic              wdt_kick_i,
    output logic [NUM_CH-1:0] ch_rst_o,
    output logic              seq_done_o,
    output logic              wdt_bite_o
);

    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FILT_W = $clog2(LOCK_FILTER + 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_DELAY     = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic [FILT_W-1:0]       r_filt;
    logic [FILT_W-1:0]       w_filt_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [IDX_W-1:0]        w_idx_inc;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;
    logic [NUM_CH-1:0]       r_ch_rst;
    logic [NUM_CH-1:0]       w_ch_rst_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    w_lock_s;
    logic                    w_wdt_expire;
    logic                    w_abort;
    logic                    w_filt_done;
    logic                    w_release;
    logic                    w_last;
    logic [CNT_WIDTH-1:0]    w_delay [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_delay
        assign w_delay[g] = CH_DELAY[g*CNT_WIDTH +: CNT_WIDTH];
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked_i};
        end
    end

    assign w_lock_s    = r_sync[SYNC_STAGES-1];
    assign w_abort     = (r_state != S_WAIT_LOCK) && (!w_lock_s || sw_rst_i || w_wdt_expire);
    assign w_filt_done = (r_state == S_WAIT_LOCK) && w_lock_s && !sw_rst_i &&
                         (r_filt == FILT_W'(LOCK_FILTER - 1));
    assign w_release   = (r_state == S_DELAY) && (r_cnt == '0);
    assign w_last      = (r_idx == IDX_W'(NUM_CH - 1));
    assign w_idx_inc   = r_idx + IDX_W'(1);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_WAIT_LOCK;
            r_filt   <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_ch_rst <= '1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_filt   <= w_filt_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ch_rst <= w_ch_rst_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_LOCK: if (w_filt_done) w_state_nxt = S_DELAY;
            S_DELAY: begin
                if (w_abort)                    w_state_nxt = S_WAIT_LOCK;
                else if (w_release && w_last)   w_state_nxt = S_RUN;
            end
            S_RUN:       if (w_abort) w_state_nxt = S_WAIT_LOCK;
            default:     w_state_nxt = S_WAIT_LOCK;
        endcase
    end

    // Abort overrides any release decided in the same cycle.
    always_comb begin
        w_filt_nxt   = '0;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_ch_rst_nxt = r_ch_rst;
        w_done_nxt   = r_done;
        if (w_abort) begin
            w_ch_rst_nxt = '1;
            w_done_nxt   = 1'b0;
        end else if (r_state == S_WAIT_LOCK) begin
            if (w_filt_done) begin
                w_idx_nxt = '0;
                w_cnt_nxt = w_delay[0];
            end else if (w_lock_s && !sw_rst_i) begin
                w_filt_nxt = r_filt + FILT_W'(1);
            end
        end else if (r_state == S_DELAY) begin
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
            end else begin
                w_ch_rst_nxt[r_idx] = 1'b0;
                if (w_last) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_idx_nxt = w_idx_inc;
                    w_cnt_nxt = w_delay[w_idx_inc];
                end
            end
        end
    end

    assign ch_rst_o   = r_ch_rst;
    assign seq_done_o = r_done;

`ifdef SOC_RST_SEQ_WDT_EN
    logic [WDT_WIDTH-1:0] r_wdt;
    logic                 r_bite;

    // Counter is held at zero outside RUN, so it restarts from zero on every RUN entry.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt  <= '0;
            r_bite <= 1'b0;
        end else begin
            if (r_state != S_RUN || wdt_kick_i || w_wdt_expire) begin
                r_wdt <= '0;
            end else begin
                r_wdt <= r_wdt + WDT_WIDTH'(1);
            end
            if (w_wdt_expire) begin
                r_bite <= 1'b1;
            end
        end
    end

    assign w_wdt_expire = (r_state == S_RUN) && (&r_wdt);
    assign wdt_bite_o   = r_bite;
`else
    logic w_unused_kick;

    assign w_unused_kick = wdt_kick_i;
    assign w_wdt_expire  = 1'b0;
    assign wdt_bite_o    = 1'b0;
`endif

endmodule

// File: tb/tb_soc_rst_seq.sv
// tb/tb_soc_rst_seq.sv - directed self-checking bench for soc_rst_seq
module tb_soc_rst_seq;

    logic       clock;
    logic       rst_n;
    logic       pll_locked_i;
    logic       sw_rst_i;
    logic       wdt_kick_i;
    logic [3:0] ch_rst_o;
    logic       seq_done_o;
    logic       wdt_bite_o;

    int checks;
    int fails;

    soc_rst_seq #(
        .NUM_CH      (4),
        .CNT_WIDTH   (16),
        .CH_DELAY    ({16'd100, 16'd50, 16'd10, 16'd0}),
        .SYNC_STAGES (2),
        .LOCK_FILTER (8),
        .WDT_WIDTH   (4)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .pll_locked_i (pll_locked_i),
        .sw_rst_i     (sw_rst_i),
        .wdt_kick_i   (wdt_kick_i),
        .ch_rst_o     (ch_rst_o),
        .seq_done_o   (seq_done_o),
        .wdt_bite_o   (wdt_bite_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic edges_until_change(output int n);
        logic [3:0] old;
        old = ch_rst_o;
        n = 0;
        do begin
            tick();
            n++;
        end while (ch_rst_o === old && n < 400);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (seq_done_o !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pll_locked_i = 1'b1; sw_rst_i = 1'b0; wdt_kick_i = 1'b0;
        tick(); tick();
        checks++; if (ch_rst_o !== 4'hF) begin fails++; $display("FAIL reset_ch: got %h expected %h", ch_rst_o, 4'hF); end
        checks++; if (seq_done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", seq_done_o); end
        checks++; if (wdt_bite_o !== 1'b0) begin fails++; $display("FAIL reset_bite: got %b expected 0", wdt_bite_o); end
    endtask

    task automatic test_sequence();
        int n;
        rst_n = 1'b1;
        repeat (10) tick();
        checks++; if (ch_rst_o !== 4'hF) begin fails++; $display("FAIL seq_hold10: got %h expected %h", ch_rst_o, 4'hF); end
        edges_until_change(n);
        checks++; if (n !== 1 || ch_rst_o !== 4'hE) begin fails++; $display("FAIL seq_ch0: edges %0d ch %h expected 1 E", n, ch_rst_o); end
        edges_until_change(n);
        checks++; if (n !== 11 || ch_rst_o !== 4'hC) begin fails++; $display("FAIL seq_ch1: edges %0d ch %h expected 11 C", n, ch_rst_o); end
        edges_until_change(n);
        checks++; if (n !== 51 || ch_rst_o !== 4'h8 || seq_done_o !== 1'b0) begin fails++; $display("FAIL seq_ch2: edges %0d ch %h done %b expected 51 8 0", n, ch_rst_o, seq_done_o); end
        edges_until_change(n);
        checks++; if (n !== 101 || ch_rst_o !== 4'h0 || seq_done_o !== 1'b1) begin fails++; $display("FAIL seq_ch3: edges %0d ch %h done %b expected 101 0 1", n, ch_rst_o, seq_done_o); end
    endtask

    task automatic test_lock_glitch();
        int n;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (7) tick();
        pll_locked_i = 1'b0;
        repeat (3) tick();
        pll_locked_i = 1'b1;
        edges_until_change(n);
        checks++; if (n !== 11 || ch_rst_o !== 4'hE) begin fails++; $display("FAIL glitch_restart: edges %0d ch %h expected 11 E", n, ch_rst_o); end
        wait_done(n);
        checks++; if (seq_done_o !== 1'b1 || n !== 163) begin fails++; $display("FAIL glitch_done: edges %0d done %b expected 163 1", n, seq_done_o); end
    endtask

    task automatic test_lock_loss();
        int n;
        pll_locked_i = 1'b0;
        tick(); tick();
        checks++; if (ch_rst_o !== 4'h0 || seq_done_o !== 1'b1) begin fails++; $display("FAIL loss_early: ch %h done %b expected 0 1", ch_rst_o, seq_done_o); end
        tick();
        checks++; if (ch_rst_o !== 4'hF || seq_done_o !== 1'b0) begin fails++; $display("FAIL loss_abort: ch %h done %b expected F 0", ch_rst_o, seq_done_o); end
        repeat (5) tick();
        pll_locked_i = 1'b1;
        edges_until_change(n);
        checks++; if (n !== 11 || ch_rst_o !== 4'hE) begin fails++; $display("FAIL loss_ch0: edges %0d ch %h expected 11 E", n, ch_rst_o); end
        edges_until_change(n);
        checks++; if (n !== 11 || ch_rst_o !== 4'hC) begin fails++; $display("FAIL loss_ch1: edges %0d ch %h expected 11 C", n, ch_rst_o); end
        edges_until_change(n);
        checks++; if (n !== 51 || ch_rst_o !== 4'h8) begin fails++; $display("FAIL loss_ch2: edges %0d ch %h expected 51 8", n, ch_rst_o); end
        edges_until_change(n);
        checks++; if (n !== 101 || ch_rst_o !== 4'h0 || seq_done_o !== 1'b1) begin fails++; $display("FAIL loss_ch3: edges %0d ch %h done %b expected 101 0 1", n, ch_rst_o, seq_done_o); end
    endtask

    task automatic test_soft_reset();
        int n;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        edges_until_change(n);
        checks++; if (n !== 11 || ch_rst_o !== 4'hE) begin fails++; $display("FAIL sw_pre_ch0: edges %0d ch %h expected 11 E", n, ch_rst_o); end
        repeat (3) tick();
        sw_rst_i = 1'b1;
        tick();
        checks++; if (ch_rst_o !== 4'hF || seq_done_o !== 1'b0) begin fails++; $display("FAIL sw_abort: ch %h done %b expected F 0", ch_rst_o, seq_done_o); end
        repeat (19) tick();
        checks++; if (ch_rst_o !== 4'hF) begin fails++; $display("FAIL sw_hold: got %h expected %h", ch_rst_o, 4'hF); end
        sw_rst_i = 1'b0;
        edges_until_change(n);
        checks++; if (n !== 9 || ch_rst_o !== 4'hE) begin fails++; $display("FAIL sw_restart: edges %0d ch %h expected 9 E", n, ch_rst_o); end
    endtask

    task automatic test_async_reset();
        repeat (4) tick();
        checks++; if (ch_rst_o !== 4'hE) begin fails++; $display("FAIL async_pre: got %h expected %h", ch_rst_o, 4'hE); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ch_rst_o !== 4'hF || seq_done_o !== 1'b0 || wdt_bite_o !== 1'b0) begin fails++; $display("FAIL async_now: ch %h done %b bite %b expected F 0 0", ch_rst_o, seq_done_o, wdt_bite_o); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_watchdog();
        int n;
        wait_done(n);
        checks++; if (seq_done_o !== 1'b1 || n !== 174) begin fails++; $display("FAIL wdt_run: edges %0d done %b expected 174 1", n, seq_done_o); end
        for (int i = 0; i < 60; i++) begin
            wdt_kick_i = (i % 10 == 9);
            tick();
        end
        wdt_kick_i = 1'b0;
        checks++; if (wdt_bite_o !== 1'b0 || seq_done_o !== 1'b1 || ch_rst_o !== 4'h0) begin fails++; $display("FAIL wdt_kicked: bite %b done %b ch %h expected 0 1 0", wdt_bite_o, seq_done_o, ch_rst_o); end
`ifdef SOC_RST_SEQ_WDT_EN
        wdt_kick_i = 1'b1;
        tick();
        wdt_kick_i = 1'b0;
        repeat (15) tick();
        checks++; if (wdt_bite_o !== 1'b0 || ch_rst_o !== 4'h0) begin fails++; $display("FAIL wdt_15: bite %b ch %h expected 0 0", wdt_bite_o, ch_rst_o); end
        tick();
        checks++; if (wdt_bite_o !== 1'b1 || ch_rst_o !== 4'hF || seq_done_o !== 1'b0) begin fails++; $display("FAIL wdt_16: bite %b ch %h done %b expected 1 F 0", wdt_bite_o, ch_rst_o, seq_done_o); end
        wait_done(n);
        repeat (15) tick();
        checks++; if (ch_rst_o !== 4'h0 || wdt_bite_o !== 1'b1) begin fails++; $display("FAIL wdt_entry15: ch %h bite %b expected 0 1", ch_rst_o, wdt_bite_o); end
        tick();
        checks++; if (ch_rst_o !== 4'hF || wdt_bite_o !== 1'b1) begin fails++; $display("FAIL wdt_entry16: ch %h bite %b expected F 1", ch_rst_o, wdt_bite_o); end
`else
        repeat (40) tick();
        checks++; if (wdt_bite_o !== 1'b0 || seq_done_o !== 1'b1 || ch_rst_o !== 4'h0) begin fails++; $display("FAIL wdt_off: bite %b done %b ch %h expected 0 1 0", wdt_bite_o, seq_done_o, ch_rst_o); end
`endif
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_sequence();
        test_lock_glitch();
        test_lock_loss();
        test_soft_reset();
        test_async_reset();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
